// File: rtl/axi_data_mem_slave.sv
// -----------------------------------------------------------------------------
// axi_data_mem_slave
//
// AXI4 slave in front of a word-organised data memory for the MCU master.
// Only one transaction is in flight at a time. Every burst is treated as INCR
// with 4-byte beats; size and burst type are ignored. Beats that fall outside
// the memory are dropped on write, or return zero with DECERR on read.
//
// Optional feature (macro AXI_MEM_STALL_EN): when defined, one wait cycle is
// inserted after every accepted W or R beat.
//
// Ports:
//   clk, reset_n            - clock (posedge) and async active-low reset
//   s_axi_aw*               - write address channel (awready combinational)
//   s_axi_w*                - write data channel
//   s_axi_b*                - write response channel (registered)
//   s_axi_ar*               - read address channel (arready combinational)
//   s_axi_r*                - read data channel (registered)
// -----------------------------------------------------------------------------
module axi_data_mem_slave #(
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int MEM_DEPTH_WORDS    = 1024
) (
    input  logic                          clk,
    input  logic                          reset_n,
    // write address
    input  logic [C_S_AXI_ID_WIDTH-1:0]   s_axi_awid,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]                    s_axi_awlen,
    input  logic [2:0]                    s_axi_awsize,
    input  logic [1:0]                    s_axi_awburst,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    // write data
    input  logic [C_S_AXI_DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [3:0]                    s_axi_wstrb,
    input  logic                          s_axi_wlast,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    // write response
    output logic [C_S_AXI_ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    // read address
    input  logic [C_S_AXI_ID_WIDTH-1:0]   s_axi_arid,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]                    s_axi_arlen,
    input  logic [2:0]                    s_axi_arsize,
    input  logic [1:0]                    s_axi_arburst,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    // read data
    output logic [C_S_AXI_ID_WIDTH-1:0]   s_axi_rid,
    output logic [C_S_AXI_DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rlast,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready
);

    localparam int WA    = C_S_AXI_ADDR_WIDTH - 2;
    localparam int IDX_W = (MEM_DEPTH_WORDS > 1) ? $clog2(MEM_DEPTH_WORDS) : 1;
    localparam logic [WA-1:0] DEPTH_W = WA'(MEM_DEPTH_WORDS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2,
        R_DATA = 2'd3
    } state_t;

    // Byte-lane merge of a new word into an old word under a strobe.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = strb[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return merged;
    endfunction

    logic [31:0] mem [0:MEM_DEPTH_WORDS-1];

    state_t                         state_r;
    state_t                         state_next_s;
    logic [WA-1:0]                  addr_r;
    logic [7:0]                     len_r;
    logic [7:0]                     cnt_r;
    logic                           werr_r;
    logic                           stall_r;
    logic [C_S_AXI_ID_WIDTH-1:0]    bid_r;
    logic [1:0]                     bresp_r;
    logic                           bvalid_r;
    logic [C_S_AXI_ID_WIDTH-1:0]    rid_r;
    logic [31:0]                    rdata_r;
    logic [1:0]                     rresp_r;
    logic                           rlast_r;
    logic                           rvalid_r;

    logic                           aw_fire_s;
    logic                           ar_fire_s;
    logic                           w_fire_s;
    logic                           r_fire_s;
    logic                           wr_oor_s;
    logic [WA-1:0]                  rd_addr_s;
    logic                           rd_oor_s;
    logic [31:0]                    rd_word_s;
    logic                           unused_s;

    // Handshake strobes; write wins over read when both addresses arrive together.
    assign s_axi_awready = (state_r == IDLE);
    assign s_axi_arready = (state_r == IDLE) && !s_axi_awvalid;
    assign s_axi_wready  = (state_r == W_DATA) && !stall_r;

    assign aw_fire_s = s_axi_awvalid && s_axi_awready;
    assign ar_fire_s = s_axi_arvalid && s_axi_arready;
    assign w_fire_s  = s_axi_wvalid && s_axi_wready;
    assign r_fire_s  = rvalid_r && s_axi_rready;
    assign wr_oor_s  = (addr_r >= DEPTH_W);

    assign s_axi_bid    = bid_r;
    assign s_axi_bresp  = bresp_r;
    assign s_axi_bvalid = bvalid_r;
    assign s_axi_rid    = rid_r;
    assign s_axi_rdata  = rdata_r;
    assign s_axi_rresp  = rresp_r;
    assign s_axi_rlast  = rlast_r;
    assign s_axi_rvalid = rvalid_r;

    // Fields that carry no information for this slave.
    assign unused_s = ^{s_axi_awsize, s_axi_awburst, s_axi_arsize, s_axi_arburst,
                        s_axi_wlast, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // Word address for the next read beat to be loaded into the output register.
    always_comb begin
        rd_addr_s = addr_r;
        if (state_r == IDLE) begin
            rd_addr_s = s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
        end else if (stall_r) begin
            // address was already advanced on the accepted beat
            rd_addr_s = addr_r;
        end else begin
            rd_addr_s = addr_r + WA'(1);
        end
    end

    // Memory lookup with out-of-range beats returning zero.
    always_comb begin
        rd_oor_s  = (rd_addr_s >= DEPTH_W);
        rd_word_s = 32'h0000_0000;
        if (!rd_oor_s) begin
            rd_word_s = mem[rd_addr_s[IDX_W-1:0]];
        end else begin
            rd_word_s = 32'h0000_0000;
        end
    end

    // Next-state logic for the transaction FSM.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (s_axi_awvalid) begin
                    state_next_s = W_DATA;
                end else if (s_axi_arvalid) begin
                    state_next_s = R_DATA;
                end else begin
                    state_next_s = IDLE;
                end
            end
            W_DATA: begin
                if (w_fire_s && (cnt_r == len_r)) begin
                    state_next_s = W_RESP;
                end else begin
                    state_next_s = W_DATA;
                end
            end
            W_RESP: begin
                if (bvalid_r && s_axi_bready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = W_RESP;
                end
            end
            R_DATA: begin
                if (r_fire_s && rlast_r) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = R_DATA;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Burst bookkeeping and registered B/R channel outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_r   <= '0;
            len_r    <= 8'd0;
            cnt_r    <= 8'd0;
            werr_r   <= 1'b0;
            stall_r  <= 1'b0;
            bid_r    <= '0;
            bresp_r  <= 2'b00;
            bvalid_r <= 1'b0;
            rid_r    <= '0;
            rdata_r  <= 32'h0000_0000;
            rresp_r  <= 2'b00;
            rlast_r  <= 1'b0;
            rvalid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    stall_r <= 1'b0;
                    if (aw_fire_s) begin
                        bid_r  <= s_axi_awid;
                        addr_r <= s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
                        len_r  <= s_axi_awlen;
                        cnt_r  <= 8'd0;
                        werr_r <= 1'b0;
                    end else if (ar_fire_s) begin
                        rid_r    <= s_axi_arid;
                        addr_r   <= s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
                        len_r    <= s_axi_arlen;
                        cnt_r    <= 8'd0;
                        rdata_r  <= rd_word_s;
                        rresp_r  <= rd_oor_s ? RESP_DECERR : RESP_OKAY;
                        rlast_r  <= (s_axi_arlen == 8'd0);
                        rvalid_r <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_fire_s) begin
                        addr_r <= addr_r + WA'(1);
                        cnt_r  <= cnt_r + 8'd1;
                        werr_r <= werr_r | wr_oor_s;
                        if (cnt_r == len_r) begin
                            bvalid_r <= 1'b1;
                            bresp_r  <= (werr_r | wr_oor_s) ? RESP_DECERR : RESP_OKAY;
                        end
`ifdef AXI_MEM_STALL_EN
                        stall_r <= 1'b1;
`endif
                    end else begin
                        stall_r <= 1'b0;
                    end
                end
                W_RESP: begin
                    stall_r <= 1'b0;
                    if (bvalid_r && s_axi_bready) begin
                        bvalid_r <= 1'b0;
                    end
                end
                R_DATA: begin
                    if (r_fire_s) begin
                        if (rlast_r) begin
                            rvalid_r <= 1'b0;
                            rlast_r  <= 1'b0;
                        end else begin
                            addr_r <= addr_r + WA'(1);
                            cnt_r  <= cnt_r + 8'd1;
`ifdef AXI_MEM_STALL_EN
                            rvalid_r <= 1'b0;
                            stall_r  <= 1'b1;
`else
                            rdata_r <= rd_word_s;
                            rresp_r <= rd_oor_s ? RESP_DECERR : RESP_OKAY;
                            rlast_r <= ((cnt_r + 8'd1) == len_r);
`endif
                        end
                    end else if (stall_r) begin
                        // wait cycle over: present the beat at the advanced address
                        rdata_r  <= rd_word_s;
                        rresp_r  <= rd_oor_s ? RESP_DECERR : RESP_OKAY;
                        rlast_r  <= (cnt_r == len_r);
                        rvalid_r <= 1'b1;
                        stall_r  <= 1'b0;
                    end
                end
                default: begin
                    stall_r  <= 1'b0;
                    bvalid_r <= 1'b0;
                    rvalid_r <= 1'b0;
                end
            endcase
        end
    end

    // Storage array; deliberately not reset so contents survive reset.
    always_ff @(posedge clk) begin
        if (w_fire_s && !wr_oor_s) begin
            mem[addr_r[IDX_W-1:0]] <= merge_bytes(mem[addr_r[IDX_W-1:0]],
                                                  s_axi_wdata, s_axi_wstrb);
        end
    end

endmodule

// File: tb/tb_axi_data_mem_slave.sv
// -----------------------------------------------------------------------------
// tb_axi_data_mem_slave
//
// Directed bench for axi_data_mem_slave: burst write/readback, byte strobes,
// AW/AR collision priority, read back-pressure, out-of-range decode errors and
// reset in the middle of a read burst. Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_axi_data_mem_slave;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [0:0]  awid, bid, arid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic [3:0]  wstrb;

    int checks = 0;
    int errors = 0;

    logic [31:0] wr_buf  [0:15];
    logic [31:0] rd_data [0:15];
    logic [1:0]  rd_resp [0:15];
    logic        rd_last [0:15];
    int          rd_wait [0:15];
    logic [1:0]  wr_bresp;
    logic        wr_bid;

    axi_data_mem_slave #(
        .C_S_AXI_ADDR_WIDTH(32),
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ID_WIDTH(1),
        .MEM_DEPTH_WORDS(1024)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
        .s_axi_awsize(awsize), .s_axi_awburst(awburst), .s_axi_awvalid(awvalid),
        .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
        .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
        .s_axi_arsize(arsize), .s_axi_arburst(arburst), .s_axi_arvalid(arvalid),
        .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
        .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write burst from wr_buf; wlast only on beat 0 to show it is not used for termination.
    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] strb);
        int n;
        awid = 1'b1; awaddr = addr; awlen = len; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 50) begin tick(); n++; end
        if (n >= 50) check_val("aw_timeout", 32'd0, 32'd1);
        tick();
        awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            wvalid = 1'b1; wdata = wr_buf[b]; wstrb = strb; wlast = (b == 0);
            n = 0;
            while (!wready && n < 50) begin tick(); n++; end
            if (n >= 50) check_val("w_timeout", 32'd0, 32'd1);
            tick();
        end
        wvalid = 1'b0; wlast = 1'b0;
        bready = 1'b1;
        n = 0;
        while (!bvalid && n < 50) begin tick(); n++; end
        if (n >= 50) check_val("b_timeout", 32'd0, 32'd1);
        wr_bresp = bresp;
        wr_bid   = bid;
        tick();
        bready = 1'b0;
    endtask

    // Read burst into rd_*; optionally back-pressures beat 0 and checks it stays put.
    task automatic do_read(input logic [31:0] addr, input logic [7:0] len,
                           input int hold0, input logic [31:0] exp0);
        int n;
        arid = 1'b1; araddr = addr; arlen = len; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin tick(); n++; end
        if (n >= 50) check_val("ar_timeout", 32'd0, 32'd1);
        tick();
        arvalid = 1'b0;
        rready = (hold0 == 0);
        for (int b = 0; b <= int'(len); b++) begin
            n = 0;
            while (!rvalid && n < 50) begin tick(); n++; end
            if (n >= 50) check_val("r_timeout", 32'd0, 32'd1);
            rd_wait[b] = n;
            rd_data[b] = rdata;
            rd_resp[b] = rresp;
            rd_last[b] = rlast;
            if (b == 0 && hold0 > 0) begin
                for (int h = 0; h < hold0; h++) begin
                    tick();
                    check_val("hold_rvalid", {31'd0, rvalid}, 32'd1);
                    check_val("hold_rdata", rdata, exp0);
                    check_val("hold_rlast", {31'd0, rlast}, 32'd0);
                end
                rready = 1'b1;
            end
            tick();
        end
        rready = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        awid = 1'b0; awaddr = 32'd0; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b0;
        wdata = 32'd0; wstrb = 4'h0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = 1'b0; araddr = 32'd0; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b0;
        rready = 1'b0;
        for (int i = 0; i < 16; i++) wr_buf[i] = 32'd0;
        #12;
        // reset state
        check_val("rst_bvalid", {31'd0, bvalid}, 32'd0);
        check_val("rst_rvalid", {31'd0, rvalid}, 32'd0);
        check_val("rst_rlast", {31'd0, rlast}, 32'd0);
        check_val("rst_rdata", rdata, 32'd0);
        check_val("rst_bresp", {30'd0, bresp}, 32'd0);
        check_val("rst_rresp", {30'd0, rresp}, 32'd0);
        reset_n = 1'b1;
        tick();
        check_val("idle_awready", {31'd0, awready}, 32'd1);
        check_val("idle_arready", {31'd0, arready}, 32'd1);

        // 4-beat write then readback at 0x40
        for (int i = 0; i < 4; i++) wr_buf[i] = 32'h11 * (i + 1);
        do_write(32'h40, 8'd3, 4'hF);
        check_val("wr4_bresp", {30'd0, wr_bresp}, 32'd0);
        check_val("wr4_bid", {31'd0, wr_bid}, 32'd1);
        do_read(32'h40, 8'd3, 0, 32'd0);
        check_val("rd4_idle", {31'd0, arready}, 32'd1);
        for (int b = 0; b < 4; b++) begin
            check_val("rd4_data", rd_data[b], 32'h11 * (b + 1));
            check_val("rd4_resp", {30'd0, rd_resp[b]}, 32'd0);
            check_val("rd4_last", {31'd0, rd_last[b]}, (b == 3) ? 32'd1 : 32'd0);
            check_val("rd4_wait", rd_wait[b], 32'd0);
        end
        check_val("rd4_rid", {31'd0, rid}, 32'd1);

        // byte strobes on word 5
        wr_buf[0] = 32'hAABBCCDD;
        do_write(32'h14, 8'd0, 4'hF);
        wr_buf[0] = 32'h11223344;
        do_write(32'h14, 8'd0, 4'h3);
        do_read(32'h14, 8'd0, 0, 32'd0);
        check_val("strb_data", rd_data[0], 32'hAABB3344);
        check_val("strb_last", {31'd0, rd_last[0]}, 32'd1);

        // AW and AR together: write first
        arid = 1'b1; araddr = 32'h80; arlen = 8'd0; arvalid = 1'b1;
        awid = 1'b1; awaddr = 32'h80; awlen = 8'd0; awvalid = 1'b1;
        #1;
        check_val("coll_awready", {31'd0, awready}, 32'd1);
        check_val("coll_arready", {31'd0, arready}, 32'd0);
        wr_buf[0] = 32'h5A5A5A5A;
        do_write(32'h80, 8'd0, 4'hF);
        check_val("coll_bresp", {30'd0, wr_bresp}, 32'd0);
        check_val("coll_arready_after", {31'd0, arready}, 32'd1);
        do_read(32'h80, 8'd0, 0, 32'd0);
        check_val("coll_rdata", rd_data[0], 32'h5A5A5A5A);

        // back-pressure on beat 0 of a 2-beat read
        do_read(32'h40, 8'd1, 3, 32'h11);
        check_val("bp_data0", rd_data[0], 32'h11);
        check_val("bp_data1", rd_data[1], 32'h22);
        check_val("bp_wait1", rd_wait[1], 32'd0);
        check_val("bp_last1", {31'd0, rd_last[1]}, 32'd1);

        // out of range at top of memory
        wr_buf[0] = 32'hCAFE0001; wr_buf[1] = 32'hCAFE0002;
        do_write(32'hFFC, 8'd1, 4'hF);
        check_val("oor_bresp", {30'd0, wr_bresp}, 32'd3);
        do_read(32'hFFC, 8'd1, 0, 32'd0);
        check_val("oor_data0", rd_data[0], 32'hCAFE0001);
        check_val("oor_resp0", {30'd0, rd_resp[0]}, 32'd0);
        check_val("oor_data1", rd_data[1], 32'd0);
        check_val("oor_resp1", {30'd0, rd_resp[1]}, 32'd3);
        check_val("oor_last1", {31'd0, rd_last[1]}, 32'd1);

        // reset during beat 2 of an 8-beat read
        arid = 1'b1; araddr = 32'h40; arlen = 8'd7; arvalid = 1'b1;
        tick();
        arvalid = 1'b0; rready = 1'b1;
        check_val("mid_beat0", rdata, 32'h11);
        tick();
        check_val("mid_beat1", rdata, 32'h22);
        tick();
        check_val("mid_beat2", rdata, 32'h33);
        reset_n = 1'b0;
        #1;
        check_val("mid_rvalid", {31'd0, rvalid}, 32'd0);
        check_val("mid_rdata", rdata, 32'd0);
        check_val("mid_rlast", {31'd0, rlast}, 32'd0);
        rready = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        check_val("post_rst_arready", {31'd0, arready}, 32'd1);
        do_read(32'h48, 8'd0, 0, 32'd0);
        check_val("post_rst_data", rd_data[0], 32'h33);
        check_val("post_rst_wait", rd_wait[0], 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_data_mem_slave.md
AXI_DATA_MEM_SLAVE -- requirements
Module: axi_data_mem_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 32, byte-address width.
REQ-002 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, data width; fixed 32 in this revision.
REQ-003 SHALL have parameter C_S_AXI_ID_WIDTH, default 1, ID width.
REQ-004 SHALL have parameter MEM_DEPTH_WORDS, default 1024, word count of internal storage.
REQ-005 SHALL have port clk, input, 1 bit; one clock, all logic on posedge.
REQ-006 SHALL have port reset_n, input, 1 bit; reset is asynchronous and active-low.
REQ-007 SHALL have write-address ports s_axi_awid/awaddr/awlen[7:0]/awsize[2:0]/awburst[1:0]/awvalid as inputs and s_axi_awready as output.
REQ-008 SHALL have write-data ports s_axi_wdata/wstrb[3:0]/wlast/wvalid as inputs and s_axi_wready as output.
REQ-009 SHALL have write-response ports s_axi_bid/bresp[1:0]/bvalid as outputs and s_axi_bready as input.
REQ-010 SHALL have read-address ports s_axi_arid/araddr/arlen[7:0]/arsize[2:0]/arburst[1:0]/arvalid as inputs and s_axi_arready as output.
REQ-011 SHALL have read-data ports s_axi_rid/rdata/rresp[1:0]/rlast/rvalid as outputs and s_axi_rready as input.

Function
REQ-012 SHALL be an AXI4 slave for the MCU master: one outstanding transaction; INCR bursts of 1-256 beats; 4-byte beats.
REQ-013 SHALL implement FSM states IDLE, W_DATA, W_RESP, R_DATA.
REQ-014 IDLE SHALL assert awready and arready combinationally; if awvalid and arvalid are both high, SHALL accept write only and hold arready low that cycle.
REQ-015 AW handshake SHALL latch id, word address (awaddr>>2), and len, then go to W_DATA.
REQ-016 AR handshake SHALL latch id, word address (araddr>>2), and len, then go to R_DATA.
REQ-017 awsize/arsize/awburst/arburst SHALL be ignored; every burst is INCR with 4-byte beats.
REQ-018 W_DATA SHALL hold wready=1. Each wvalid&&wready beat SHALL write the bytes enabled by wstrb at the current word, then increment the word address by 1.
REQ-019 W_DATA SHALL go to W_RESP on the beat where the beat count equals len; wlast SHALL be ignored for termination.
REQ-020 W_RESP SHALL drive bvalid=1 and bid=latched id, holding them until bready; IDLE SHALL follow the cycle after bvalid&&bready.
REQ-021 R_DATA SHALL assert rvalid first in the cycle after the AR handshake, carrying the data for the start word.
REQ-022 After each rvalid&&rready beat, the next beat's rvalid SHALL be high the following cycle (full throughput).
REQ-023 rdata/rresp/rlast/rid SHALL stay stable while rvalid && !rready.
REQ-024 rlast SHALL be 1 only on beat len. IDLE SHALL follow the cycle after the last beat handshakes.
REQ-025 Out-of-range beat (word address >= MEM_DEPTH_WORDS): write SHALL be dropped; read SHALL return rdata=0 with rresp=DECERR (2'b11) for that beat only.
REQ-026 If any beat of a write burst was out of range, bresp SHALL be DECERR; otherwise OKAY.
REQ-027 Word-address increment SHALL be ADDR_WIDTH-2 bits wide and wrap modulo its width; no 4 KB boundary check.

Reset
REQ-028 reset_n low SHALL immediately force state IDLE and drive bvalid=0, rvalid=0, rlast=0, rresp=0, bresp=0, rdata=0, bid=0, rid=0.
REQ-029 Memory contents SHALL NOT be cleared by reset.
REQ-030 A reset asserted mid-burst SHALL abort the burst. Beats already written SHALL remain written.

Configuration
REQ-031 With macro AXI_MEM_STALL_EN defined, the block SHALL insert one wait cycle after every accepted W or R beat (wready or rvalid low for one cycle). REQ-023 SHALL still hold.
REQ-032 Without AXI_MEM_STALL_EN, the block SHALL run at full throughput per REQ-018 and REQ-022.

Verification
REQ-033 Write awaddr=0x40, awlen=3, data 0x11..0x44, wstrb=0xF, then read araddr=0x40, arlen=3 -> rdata 0x11,0x22,0x33,0x44; rlast on beat 3; bresp=OKAY and rresp=OKAY.
REQ-034 Pre-load word 5=0xAABBCCDD; write one beat 0x11223344 at 0x14 with wstrb=0x3 -> read of 0x14 returns 0xAABB3344.
REQ-035 awvalid and arvalid asserted in the same cycle -> only awready=1; after B completes, arready=1 and the read completes.
REQ-036 Read arlen=1 with rready low for 3 cycles on beat 0 -> rdata/rlast held stable; beat 1 follows the cycle after the handshake.
REQ-037 Read starting at word MEM_DEPTH_WORDS-1, arlen=1 -> beat 0 rresp=OKAY, beat 1 rdata=0 with rresp=DECERR.
REQ-038 reset_n pulsed low during beat 2 of an 8-beat read -> rvalid=0 immediately; after release the next AR is accepted from IDLE.
